// File: rtl/udp_payload_arb_if.sv
// AXI-stream style bundle used by udp_payload_arb, N lanes wide.
// master drives tdata/tkeep/tvalid/tlast/tid; slave drives tready.
interface udp_payload_arb_if #(
    parameter int DATA_W = 32,
    parameter int N      = 1,
    parameter int ID_W   = 1
);
    logic [N*DATA_W-1:0]   tdata;
    logic [N*DATA_W/8-1:0] tkeep;
    logic [N-1:0]          tvalid;
    logic [N-1:0]          tready;
    logic [N-1:0]          tlast;
    logic [ID_W-1:0]       tid;

    modport master (
        output tdata, tkeep, tvalid, tlast, tid,
        input  tready
    );

    // Upstream lanes carry no id; the arbiter generates it.
    modport slave (
        input  tdata, tkeep, tvalid, tlast,
        output tready
    );
endinterface

// File: rtl/udp_payload_arb.sv
// Round-robin packet arbiter: NUM_PORTS payload streams onto one stream.
// Ports: clk, rst_n (async, active low), s_axis (slave, NUM_PORTS lanes),
//        m_axis (master, 1 lane, tid = source), pkt_count, trunc_count.
// Optional macro UDP_ARB_PKT_LIMIT_EN: truncate packets at MAX_BEATS beats
// and discard the remainder of the truncated input packet.
module udp_payload_arb #(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int NUM_PORTS       = 2,
    parameter int MAX_BEATS       = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    udp_payload_arb_if.slave  s_axis,
    udp_payload_arb_if.master m_axis,
    output logic [15:0]       pkt_count,
    output logic [15:0]       trunc_count
);
    localparam int ID_W   = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;
    localparam int KEEP_W = AXIS_DATA_WIDTH / 8;

    generate
        if (AXIS_DATA_WIDTH % 8 != 0) begin : g_bad_width
            $error("AXIS_DATA_WIDTH must be a multiple of 8");
        end
        if (NUM_PORTS < 2 || NUM_PORTS > 4) begin : g_bad_ports
            $error("NUM_PORTS must be 2..4");
        end
        if (MAX_BEATS < 2) begin : g_bad_beats
            $error("MAX_BEATS must be >= 2");
        end
    endgenerate

`ifdef UDP_ARB_PKT_LIMIT_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DROP   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1
    } state_t;
`endif

    state_t          state;
    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] next_grant;
    logic            sel_valid;
    logic            sel_last;
    logic            accept;
    logic            trunc_beat;

    assign sel_valid = s_axis.tvalid[grant];
    assign sel_last  = s_axis.tlast[grant];
    assign accept    = (state == STREAM) && sel_valid && m_axis.tready[0];

    // First requester found scanning upward from last_grant+1, wrapping.
    always_comb begin
        int  idx;
        logic found;
        next_grant = last_grant;
        found      = 1'b0;
        idx        = 0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            idx = (int'(last_grant) + i) % NUM_PORTS;
            if (!found && s_axis.tvalid[idx]) begin
                next_grant = ID_W'(idx);
                found      = 1'b1;
            end
        end
    end

`ifdef UDP_ARB_PKT_LIMIT_EN
    localparam int BEAT_W = $clog2(MAX_BEATS + 1);

    // Beats already accepted in the current packet.
    logic [BEAT_W-1:0] beat_cnt;

    assign trunc_beat = accept && !sel_last &&
                        (beat_cnt == BEAT_W'(MAX_BEATS - 1));
`else
    assign trunc_beat = 1'b0;
`endif

    always_comb begin
        s_axis.tready = '0;
        m_axis.tvalid = 1'b0;
        m_axis.tdata  = '0;
        m_axis.tkeep  = '0;
        m_axis.tlast  = 1'b0;
        m_axis.tid    = grant;
        unique case (state)
            STREAM: begin
                s_axis.tready[grant] = m_axis.tready[0];
                if (sel_valid) begin
                    m_axis.tvalid = 1'b1;
                    m_axis.tdata  = s_axis.tdata[grant*AXIS_DATA_WIDTH +:
                                                 AXIS_DATA_WIDTH];
                    m_axis.tkeep  = s_axis.tkeep[grant*KEEP_W +: KEEP_W];
                    m_axis.tlast  = sel_last | trunc_beat;
                end
            end
`ifdef UDP_ARB_PKT_LIMIT_EN
            DROP: begin
                s_axis.tready[grant] = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= ID_W'(NUM_PORTS - 1);
            pkt_count  <= '0;
`ifdef UDP_ARB_PKT_LIMIT_EN
            beat_cnt    <= '0;
            trunc_count <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (|s_axis.tvalid) begin
                        grant <= next_grant;
                        state <= STREAM;
`ifdef UDP_ARB_PKT_LIMIT_EN
                        beat_cnt <= '0;
`endif
                    end
                end
                STREAM: begin
                    if (accept) begin
                        if (sel_last) begin
                            last_grant <= grant;
                            pkt_count  <= pkt_count + 16'd1;
                            state      <= IDLE;
`ifdef UDP_ARB_PKT_LIMIT_EN
                        end else if (trunc_beat) begin
                            last_grant  <= grant;
                            pkt_count   <= pkt_count + 16'd1;
                            trunc_count <= trunc_count + 16'd1;
                            state       <= DROP;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
`endif
                        end
                    end
                end
`ifdef UDP_ARB_PKT_LIMIT_EN
                DROP: begin
                    if (sel_valid && sel_last) begin
                        state <= IDLE;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef UDP_ARB_PKT_LIMIT_EN
    assign trunc_count = '0;
`endif

endmodule
